instr_queue: RTL

Parametrised instruction queue for the multicycle MIPS core, replacing the single-entry IRWrite-gated instruction register. It sits between instruction memory (fetch) and the control/decode stage. It buffers up to DEPTH fetched words with their PCs behind a valid/ready handshake, and presents the decoded fields of the head entry to decode. A flush input discards all queued entries on taken branches and jumps.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/instr_queue_fields.sv | 35 +++
 rtl/instr_queue.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field boundaries and the opcodes the
// front end cares about.
package mips_pkg;

  localparam int INSTR_W   = 32;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JTA_MSB   = 25;
  localparam int JTA_LSB   = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/instr_queue_fields.sv
// Combinational splitter: one 32-bit MIPS word into its named fields, plus the
// sign-extended immediate.
module instr_fields
  import mips_pkg::*;
#(
  parameter int IMM_EXT_W = 32
) (
  input  logic [INSTR_W-1:0]   instr_i,
  output logic [5:0]           op_o,
  output logic [4:0]           rs_o,
  output logic [4:0]           rt_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           shamt_o,
  output logic [5:0]           funct_o,
  output logic [15:0]          imm_o,
  output logic [IMM_EXT_W-1:0] imm_sext_o,
  output logic [25:0]          jta_o
);

  logic signed [15:0] imm_s;

  assign op_o    = instr_i[OP_MSB:OP_LSB];
  assign rs_o    = instr_i[RS_MSB:RS_LSB];
  assign rt_o    = instr_i[RT_MSB:RT_LSB];
  assign rd_o    = instr_i[RD_MSB:RD_LSB];
  assign shamt_o = instr_i[SHAMT_MSB:SHAMT_LSB];
  assign funct_o = instr_i[FUNCT_MSB:FUNCT_LSB];
  assign imm_o   = instr_i[IMM_MSB:IMM_LSB];
  assign jta_o   = instr_i[JTA_MSB:JTA_LSB];

  // Size cast of a signed operand replicates bit 15 up to IMM_EXT_W.
  assign imm_s      = instr_i[IMM_MSB:IMM_LSB];
  assign imm_sext_o = IMM_EXT_W'(imm_s);

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of
// {instr, pc} with valid/ready on both sides and a priority flush.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready, and in_ready/out_valid are functions of
// registered occupancy only.
module instr_queue
  import mips_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int IMM_EXT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         instr_in,
  input  logic [PC_W-1:0]            pc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [INSTR_W-1:0]         instr_out,
  output logic [PC_W-1:0]            pc_out,
  output logic [5:0]                 op,
  output logic [5:0]                 funct,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [15:0]                imm,
  output logic [IMM_EXT_W-1:0]       imm_sext,
  output logic [25:0]                jta,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale contents never escape because
  // the head is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      instr_mem_q[wr_ptr_q] <= instr_in;
      pc_mem_q[wr_ptr_q]    <= pc_in;
    end
  end

  assign head_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign head_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign instr_out  = head_instr;
  assign pc_out     = head_pc;

  instr_fields #(
    .IMM_EXT_W (IMM_EXT_W)
  ) u_fields (
    .instr_i    (head_instr),
    .op_o       (op),
    .rs_o       (rs),
    .rt_o       (rt),
    .rd_o       (rd),
    .shamt_o    (shamt),
    .funct_o    (funct),
    .imm_o      (imm),
    .imm_sext_o (imm_sext),
    .jta_o      (jta)
  );

endmodule
